// File: rtl/if_sequencer.sv
// ---------------------------------------------------------------------------
// if_sequencer
//
// Instruction-fetch controller for a single-cycle instruction ROM.
// Owns the program counter, presents it to the ROM as a byte address and
// captures the returned word, together with its PC and PC+4, into the IF/ID
// register that feeds decode. Handles decode back-pressure (stall),
// branch/jump redirects (with a one-cycle bubble) and two terminal fault
// conditions: a misaligned redirect target, and fetching from a PC that lies
// beyond the populated ROM.
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous active-high reset
//   rom_addr     out  32     byte address to ROM (the PC register itself)
//   rom_inst     in   32     word returned combinationally by the ROM
//   stall        in   1      decode cannot accept; hold PC and IF/ID
//   redirect     in   1      branch/jump taken; load redirect_pc, flush IF/ID
//   redirect_pc  in   32     redirect target byte address
//   id_inst      out  32     registered instruction
//   id_pc        out  32     registered PC of id_inst
//   id_pc4       out  32     registered id_pc + 4
//   id_valid     out  1      id_* holds a real instruction
//   fault        out  1      sticky fault flag
//   fault_code   out  2      00 none, 01 misaligned redirect, 10 PC out of range
//   fetch_cnt    out  CNT_W  number of instructions captured (saturating)
// ---------------------------------------------------------------------------
module if_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 64,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      rom_addr,
  input  logic [31:0]      rom_inst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc4,
  output logic             id_valid,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_MISALIGN = 2'b01;
  localparam logic [1:0] CODE_RANGE    = 2'b10;

  // One bit wider than the PC so that ROM_WORDS*4 == 2^32 cannot wrap to 0.
  localparam logic [32:0] PC_LIMIT = 33'(ROM_WORDS) * 33'd4;

  // Saturating increment: the counter parks at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  state_t           state_q,    state_d;
  logic [31:0]      pc_q,       pc_d;
  logic [31:0]      id_inst_q,  id_inst_d;
  logic [31:0]      id_pc_q,    id_pc_d;
  logic [31:0]      id_pc4_q,   id_pc4_d;
  logic             id_valid_q, id_valid_d;
  logic             fault_q,    fault_d;
  logic [1:0]       fault_code_q, fault_code_d;
  logic [CNT_W-1:0] fetch_cnt_q,  fetch_cnt_d;

  // Per-edge action in RUN, resolved in priority order. At most one is set;
  // when none is set in RUN the edge is a stall and everything holds.
  logic act_misalign;
  logic act_redirect;
  logic act_range;
  logic act_capture;
  logic pc_out_of_range;

  // Full 32-bit compare, so wrap-around past 32'hFFFFFFFC never goes unseen.
  assign pc_out_of_range = ({1'b0, pc_q} >= PC_LIMIT);

  always_comb begin
    act_misalign = 1'b0;
    act_redirect = 1'b0;
    act_range    = 1'b0;
    act_capture  = 1'b0;
    if (state_q == ST_RUN) begin
      if (redirect && (redirect_pc[1:0] != 2'b00)) begin
        act_misalign = 1'b1;
      end else if (redirect) begin
        // Redirect wins over stall: the flushed slot makes the held IF/ID
        // content irrelevant to decode.
        act_redirect = 1'b1;
      end else if (stall) begin
        // hold
      end else if (pc_out_of_range) begin
        act_range = 1'b1;
      end else begin
        act_capture = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN: begin
        if (act_misalign || act_range) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  // PC, IF/ID and status next values
  always_comb begin
    pc_d         = pc_q;
    id_inst_d    = id_inst_q;
    id_pc_d      = id_pc_q;
    id_pc4_d     = id_pc4_q;
    id_valid_d   = id_valid_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    fetch_cnt_d  = fetch_cnt_q;

    if (state_q == ST_FAULT) begin
      id_valid_d = 1'b0;
    end

    if (act_misalign) begin
      fault_d      = 1'b1;
      fault_code_d = CODE_MISALIGN;
      id_valid_d   = 1'b0;
    end

    if (act_redirect) begin
      pc_d       = redirect_pc;
      id_valid_d = 1'b0;
    end

    if (act_range) begin
      fault_d      = 1'b1;
      fault_code_d = CODE_RANGE;
      id_valid_d   = 1'b0;
    end

    if (act_capture) begin
      id_inst_d   = rom_inst;
      id_pc_d     = pc_q;
      id_pc4_d    = pc_q + 32'd4;
      id_valid_d  = 1'b1;
      pc_d        = pc_q + 32'd4;
      fetch_cnt_d = sat_inc(fetch_cnt_q);
    end
  end

  // Datapath and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      id_inst_q    <= 32'h0;
      id_pc_q      <= 32'h0;
      id_pc4_q     <= 32'h0;
      id_valid_q   <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= CODE_NONE;
      fetch_cnt_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      id_inst_q    <= id_inst_d;
      id_pc_q      <= id_pc_d;
      id_pc4_q     <= id_pc4_d;
      id_valid_q   <= id_valid_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign rom_addr   = pc_q;
  assign id_inst    = id_inst_q;
  assign id_pc      = id_pc_q;
  assign id_pc4     = id_pc4_q;
  assign id_valid   = id_valid_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_if_sequencer.sv
// ---------------------------------------------------------------------------
// tb_if_sequencer
//
// Drives if_sequencer with directed scenarios and randomized stall/redirect
// traffic. A behavioural model tracks the fetch unit's architectural state;
// every capture it predicts is queued, and a negedge monitor pops the queue
// whenever the DUT's capture counter moves, while also checking the visible
// status every cycle.
// ---------------------------------------------------------------------------
module tb_if_sequencer;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          ROM_WORDS = 64;
  localparam int          CNT_W     = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      rom_addr;
  logic [31:0]      rom_inst;
  logic             stall = 1'b0;
  logic             redirect = 1'b0;
  logic [31:0]      redirect_pc = 32'h0;
  logic [31:0]      id_inst;
  logic [31:0]      id_pc;
  logic [31:0]      id_pc4;
  logic             id_valid;
  logic             fault;
  logic [1:0]       fault_code;
  logic [CNT_W-1:0] fetch_cnt;

  logic [31:0] rom_mem [ROM_WORDS];
  assign rom_inst = rom_mem[rom_addr[7:2]];

  if_sequencer #(
    .RESET_PC (RESET_PC),
    .ROM_WORDS(ROM_WORDS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_addr   (rom_addr),
    .rom_inst   (rom_inst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .id_pc4     (id_pc4),
    .id_valid   (id_valid),
    .fault      (fault),
    .fault_code (fault_code),
    .fetch_cnt  (fetch_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit tb_done = 1'b0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } cap_t;
  cap_t exp_q[$];

  // Reference model state: 0 = just out of reset, 1 = fetching, 2 = dead.
  int          m_mode;
  logic [31:0] m_pc, m_inst, m_ipc, m_ipc4;
  logic        m_vld, m_fault;
  logic [1:0]  m_code;
  int          m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = RESET_PC;
    m_inst = 0; m_ipc = 0; m_ipc4 = 0; m_vld = 0;
    m_fault = 0; m_code = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  // One rising edge of the fetch unit as the rules describe it.
  task automatic model_step();
    cap_t c;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (redirect && (redirect_pc % 4 != 0)) begin
        m_mode = 2; m_fault = 1; m_code = 2'd1; m_vld = 0;
      end else if (redirect) begin
        m_pc = redirect_pc; m_vld = 0;
      end else if (stall) begin
        // nothing moves
      end else if (longint'(m_pc) >= longint'(ROM_WORDS) * 4) begin
        m_mode = 2; m_fault = 1; m_code = 2'd2; m_vld = 0;
      end else begin
        c.inst = rom_mem[m_pc / 4 % ROM_WORDS];
        c.pc   = m_pc;
        c.pc4  = m_pc + 4;
        exp_q.push_back(c);
        m_inst = c.inst; m_ipc = c.pc; m_ipc4 = c.pc4; m_vld = 1;
        m_pc = m_pc + 4;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
    end
  endtask

  // Apply inputs, let one edge happen, advance the model, step off the edge.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    stall = st; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rand_step();
    logic [31:0] t;
    int r;
    r = $urandom_range(0, 99);
    if (r < 3)       t = ({24'h0, 6'($urandom_range(0, 63)), 2'b00}) | 32'($urandom_range(1, 3));
    else if (r < 10) t = 32'hF0 + 32'($urandom_range(0, 5)) * 4;
    else             t = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), t);
  endtask

  // Reset asserted between edges; the reset state must appear at once.
  task automatic apply_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_rom_addr", rom_addr, RESET_PC);
    chk("rst_fetch_cnt", 32'(fetch_cnt), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_fault_code", 32'(fault_code), 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  // Monitor: every-cycle status check plus scoreboard pop on each capture.
  logic [CNT_W-1:0] last_cnt = '0;
  always @(negedge clk) begin
    cap_t rec;
    if (!tb_done) begin
      chk("mon_rom_addr", rom_addr, m_pc);
      chk("mon_id_valid", 32'(id_valid), 32'(m_vld));
      chk("mon_fault", 32'(fault), 32'(m_fault));
      chk("mon_fault_code", 32'(fault_code), 32'(m_code));
      chk("mon_fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
      chk("mon_id_inst", id_inst, m_inst);
      chk("mon_id_pc", id_pc, m_ipc);
      chk("mon_id_pc4", id_pc4, m_ipc4);
      if (rst) begin
        last_cnt = fetch_cnt;
      end else if (fetch_cnt != last_cnt) begin
        last_cnt = fetch_cnt;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_unexpected_capture: got id_pc %h, expected no capture", id_pc);
        end else begin
          rec = exp_q.pop_front();
          chk("sb_inst", id_inst, rec.inst);
          chk("sb_pc", id_pc, rec.pc);
          chk("sb_pc4", id_pc4, rec.pc4);
          chk("sb_valid", 32'(id_valid), 32'h1);
        end
      end
    end
  end

  initial begin
    model_reset();
    for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = $urandom;
    rom_mem[0] = 32'h14000401;
    rom_mem[1] = 32'h14000802;
    rom_mem[2] = 32'h14000c03;

    // Boot and sequential fetch, then a stall while id_pc=4.
    apply_reset();
    step(0, 0, 0);
    chk("boot_id_valid", 32'(id_valid), 32'h0);
    chk("boot_rom_addr", rom_addr, 32'h0);
    step(0, 0, 0);
    chk("seq0_pc", id_pc, 32'h0);
    chk("seq0_inst", id_inst, 32'h14000401);
    step(0, 0, 0);
    chk("seq1_pc", id_pc, 32'h4);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    chk("stall_rom_addr", rom_addr, 32'h8);
    chk("stall_inst", id_inst, 32'h14000802);
    chk("stall_valid", 32'(id_valid), 32'h1);
    chk("stall_cnt", 32'(fetch_cnt), 32'h2);
    step(0, 0, 0);
    chk("seq2_pc", id_pc, 32'h8);
    chk("seq2_pc4", id_pc4, 32'hC);
    chk("seq2_inst", id_inst, 32'h14000c03);
    chk("seq_cnt3", 32'(fetch_cnt), 32'h3);

    // Redirect overrides a simultaneous stall.
    step(1, 1, 32'h1C);
    chk("redir_rom_addr", rom_addr, 32'h1C);
    chk("redir_bubble", 32'(id_valid), 32'h0);
    chk("redir_hold_pc", id_pc, 32'h8);
    step(0, 0, 0);
    chk("redir_pc", id_pc, 32'h1C);
    chk("redir_pc4", id_pc4, 32'h20);
    chk("redir_valid", 32'(id_valid), 32'h1);
    chk("redir_inst", id_inst, rom_mem[7]);

    // Misaligned redirect is terminal.
    step(0, 1, 32'h0000000A);
    chk("mis_fault", 32'(fault), 32'h1);
    chk("mis_code", 32'(fault_code), 32'h1);
    chk("mis_valid", 32'(id_valid), 32'h0);
    chk("mis_rom_addr", rom_addr, 32'h20);
    for (int i = 0; i < 20; i++) rand_step();
    chk("mis_sticky_code", 32'(fault_code), 32'h1);
    chk("mis_sticky_addr", rom_addr, 32'h20);

    // Run off the end of the ROM.
    apply_reset();
    step(0, 0, 0);
    step(0, 1, 32'hF8);
    step(0, 0, 0);
    chk("rng_pc_f8", id_pc, 32'hF8);
    step(0, 0, 0);
    chk("rng_pc_fc", id_pc, 32'hFC);
    chk("rng_inst_fc", id_inst, rom_mem[63]);
    step(0, 0, 0);
    chk("rng_code", 32'(fault_code), 32'h2);
    chk("rng_valid", 32'(id_valid), 32'h0);
    chk("rng_rom_addr", rom_addr, 32'h100);
    for (int i = 0; i < 10; i++) rand_step();
    chk("rng_sticky_addr", rom_addr, 32'h100);
    chk("rng_hold_pc", id_pc, 32'hFC);

    // Asynchronous reset while valid instructions are flowing.
    apply_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    chk("async_pre_valid", 32'(id_valid), 32'h1);
    apply_reset();
    step(0, 0, 0);
    chk("async_boot_valid", 32'(id_valid), 32'h0);
    step(0, 0, 0);
    chk("async_first_pc", id_pc, RESET_PC);

    // Randomized stall/redirect traffic.
    for (int round = 0; round < 5; round++) begin
      apply_reset();
      for (int i = 0; i < 200; i++) rand_step();
    end

    @(negedge clk);
    #1;
    tb_done = 1'b1;
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
